// File: rtl/regfile_wport_arb.sv
// regfile_wport_arb: register-file write-port arbiter between WB and a
// 2-deep long-unit result FIFO. Optional macro ARB_FWD_BUS_EN adds arb_to_id_bus.
module regfile_wport_arb #(
    parameter int AGE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic        lu_valid,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    output logic        lu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic        pend1,
    output logic        pend2,
    output logic        stall_req
`ifdef ARB_FWD_BUS_EN
    ,
    output logic [37:0] arb_to_id_bus
`endif
);

    localparam logic [3:0] LP_THR = 4'(AGE_MAX - 1);

    // FIFO is kept compacted: slot 0 is the head, every counted slot is live.
    logic [1:0]  r_cnt;
    logic [4:0]  r_addr [2];
    logic [31:0] r_data [2];
    logic [3:0]  r_age;
    logic        r_stall;
    logic        r_popd;

    logic        w_full;
    logic        w_wb_gnt;
    logic        w_pop;
    logic        w_sq;
    logic        w_kill0;
    logic        w_kill1;
    logic        w_keep0;
    logic        w_keep1;
    logic        w_push;
    logic [1:0]  w_n_cnt;
    logic [4:0]  w_n_a0;
    logic [4:0]  w_n_a1;
    logic [31:0] w_n_d0;
    logic [31:0] w_n_d1;
    logic [3:0]  w_n_age;

    assign w_full   = (r_cnt == 2'd2);
    assign lu_ready = !w_full;

    // A stalled pipeline hands the port to the FIFO even if WB still asserts.
    assign w_wb_gnt = wb_we && !r_stall;
    assign w_pop    = (r_cnt != 2'd0) && (!wb_we || r_stall);

    // WB is younger: a granted WB write kills older stored writes to the same reg.
    assign w_sq    = w_wb_gnt && (wb_waddr != 5'd0);
    assign w_kill0 = w_sq && (r_addr[0] == wb_waddr);
    assign w_kill1 = w_sq && (r_addr[1] == wb_waddr);
    assign w_keep0 = (r_cnt != 2'd0) && !w_pop && !w_kill0;
    assign w_keep1 = (r_cnt == 2'd2) && !w_kill1;

    // Writes to x0 are accepted from the unit but never stored.
    assign w_push  = lu_valid && lu_ready && (lu_waddr != 5'd0);

    assign w_n_cnt = {1'b0, w_keep0} + {1'b0, w_keep1} + {1'b0, w_push};
    assign w_n_a0  = w_keep0 ? r_addr[0] : (w_keep1 ? r_addr[1] : lu_waddr);
    assign w_n_d0  = w_keep0 ? r_data[0] : (w_keep1 ? r_data[1] : lu_wdata);
    assign w_n_a1  = (w_keep0 && w_keep1) ? r_addr[1] : lu_waddr;
    assign w_n_d1  = (w_keep0 && w_keep1) ? r_data[1] : lu_wdata;

    // Head still waiting means it was blocked this cycle.
    assign w_n_age = !w_keep0 ? 4'd0 :
                     (r_age == 4'hF) ? r_age : r_age + 4'd1;

    assign rf_we    = !rst && (w_wb_gnt || w_pop);
    assign rf_waddr = w_pop ? r_addr[0] : wb_waddr;
    assign rf_wdata = w_pop ? r_data[0] : wb_wdata;

    assign pend1 = (raddr1 != 5'd0) &&
                   (((r_cnt != 2'd0) && (r_addr[0] == raddr1)) ||
                    (w_full && (r_addr[1] == raddr1)));
    assign pend2 = (raddr2 != 5'd0) &&
                   (((r_cnt != 2'd0) && (r_addr[0] == raddr2)) ||
                    (w_full && (r_addr[1] == raddr2)));

    assign stall_req = r_stall;

`ifdef ARB_FWD_BUS_EN
    assign arb_to_id_bus = {rf_we, rf_waddr, rf_wdata};
`endif

    // FIFO storage and occupancy update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 2'd0;
            r_addr[0] <= 5'd0;
            r_addr[1] <= 5'd0;
            r_data[0] <= 32'd0;
            r_data[1] <= 32'd0;
        end else begin
            r_cnt     <= w_n_cnt;
            r_addr[0] <= w_n_a0;
            r_addr[1] <= w_n_a1;
            r_data[0] <= w_n_d0;
            r_data[1] <= w_n_d1;
        end
    end

    // Head ageing; stall raised on starvation, dropped one edge after a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_age   <= 4'd0;
            r_stall <= 1'b0;
            r_popd  <= 1'b0;
        end else begin
            r_age  <= w_n_age;
            r_popd <= w_pop;
            if (w_keep0 && (r_age >= LP_THR))
                r_stall <= 1'b1;
            else if (r_popd)
                r_stall <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wport_arb.sv
// tb_regfile_wport_arb: directed scenarios plus random traffic checked
// against a queue-based model of the write-port arbiter.
module tb_regfile_wport_arb;

    localparam int AGE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        pend1;
    logic        pend2;
    logic        stall_req;
`ifdef ARB_FWD_BUS_EN
    logic [37:0] arb_to_id_bus;
    logic [37:0] s_bus;
`endif

    regfile_wport_arb #(.AGE_MAX(AGE)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .lu_ready(lu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .pend1(pend1), .pend2(pend2), .stall_req(stall_req)
`ifdef ARB_FWD_BUS_EN
        , .arb_to_id_bus(arb_to_id_bus)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t m_q[$];
    int   m_age;
    bit   m_stall;
    bit   m_popd;

    logic        s_we, s_rdy, s_p1, s_p2, s_st;
    logic [4:0]  s_wa;
    logic [31:0] s_wd;
    logic        e_we, e_rdy, e_p1, e_p2, e_st;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;

    task automatic model_reset();
        m_q.delete();
        m_age   = 0;
        m_stall = 0;
        m_popd  = 0;
    endtask

    task automatic model_eval();
        bit wbg, fg;
        wbg   = wb_we && !m_stall;
        fg    = (m_q.size() > 0) && (!wb_we || m_stall);
        e_we  = wbg || fg;
        e_wa  = fg ? m_q[0].a : wb_waddr;
        e_wd  = fg ? m_q[0].d : wb_wdata;
        e_rdy = m_q.size() < 2;
        e_st  = m_stall;
        e_p1  = 0;
        e_p2  = 0;
        foreach (m_q[i]) begin
            if (raddr1 != 0 && m_q[i].a == raddr1) e_p1 = 1;
            if (raddr2 != 0 && m_q[i].a == raddr2) e_p2 = 1;
        end
    endtask

    task automatic model_edge();
        bit wbg, fg, hk, blk, push;
        int n;
        n    = m_q.size();
        wbg  = wb_we && !m_stall;
        fg   = (n > 0) && (!wb_we || m_stall);
        push = lu_valid && (n < 2) && (lu_waddr != 0);
        hk   = wbg && wb_waddr != 0 && n > 0 && m_q[0].a == wb_waddr;
        blk  = (n > 0) && !fg && !hk;
        if (blk && m_age >= AGE - 1) m_stall = 1;
        else if (m_popd) m_stall = 0;
        m_age  = blk ? ((m_age == 15) ? 15 : m_age + 1) : 0;
        m_popd = fg;
        if (fg) void'(m_q.pop_front());
        if (wbg && wb_waddr != 0)
            for (int i = m_q.size() - 1; i >= 0; i--)
                if (m_q[i].a == wb_waddr) m_q.delete(i);
        if (push) m_q.push_back('{a: lu_waddr, d: lu_wdata});
    endtask

    task automatic tick();
        @(negedge clk);
        s_we  = rf_we;
        s_wa  = rf_waddr;
        s_wd  = rf_wdata;
        s_rdy = lu_ready;
        s_p1  = pend1;
        s_p2  = pend2;
        s_st  = stall_req;
`ifdef ARB_FWD_BUS_EN
        s_bus = arb_to_id_bus;
`endif
        model_eval();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wb_we = 0; wb_waddr = 0; wb_wdata = 0;
        lu_valid = 0; lu_waddr = 0; lu_wdata = 0;
        raddr1 = 0; raddr2 = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        wb_we = 1; wb_waddr = 5'd3; lu_valid = 1; lu_waddr = 5'd4; raddr1 = 5'd4;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got %b want 0", rf_we); end
        n_chk++;
        if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall_req); end
        n_chk++;
        if ({pend1, pend2} !== 2'b00) begin n_fail++; $display("FAIL reset_pend got %b want 00", {pend1, pend2}); end
        n_chk++;
        if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_lu_ready got %b want 1", lu_ready); end
        idle();
        rst = 0;
        model_reset();
    endtask

    task automatic test_lu_basic();
        idle();
        lu_valid = 1; lu_waddr = 5'd5; lu_wdata = 32'h11; raddr1 = 5'd5;
        tick();
        n_chk++;
        if (s_we !== 1'b0) begin n_fail++; $display("FAIL lu_no_passthru got %b want 0", s_we); end
        lu_valid = 0;
        tick();
        n_chk++;
        if ({s_we, s_wa, s_wd} !== {1'b1, 5'd5, 32'h11}) begin
            n_fail++; $display("FAIL lu_write got %b/%0d/%h want 1/5/11", s_we, s_wa, s_wd);
        end
        n_chk++;
        if (s_p1 !== 1'b1) begin n_fail++; $display("FAIL lu_pend_during got %b want 1", s_p1); end
        tick();
        n_chk++;
        if ({s_we, s_p1, s_rdy} !== 3'b001) begin
            n_fail++; $display("FAIL lu_empty_after got we/p1/rdy=%b want 001", {s_we, s_p1, s_rdy});
        end
    endtask

    task automatic test_stall_age();
        logic st[12], we[12], rdy[12];
        logic [4:0] wa[12];
        logic [31:0] wd[12];
        int first;
        idle();
        wb_we = 1; wb_waddr = 5'd20;
        for (int c = 0; c < 12; c++) begin
            wb_wdata = $urandom;
            lu_valid = (c < 2);
            lu_waddr = (c == 0) ? 5'd6 : 5'd7;
            lu_wdata = (c == 0) ? 32'h66 : 32'h77;
            tick();
            st[c] = s_st; we[c] = s_we; rdy[c] = s_rdy; wa[c] = s_wa; wd[c] = s_wd;
        end
        idle();
        first = -1;
        for (int c = 11; c >= 0; c--) if (st[c] === 1'b1) first = c;
        n_chk++;
        if (rdy[2] !== 1'b0) begin n_fail++; $display("FAIL age_full_ready got %b want 0", rdy[2]); end
        n_chk++;
        if (first != AGE + 1) begin n_fail++; $display("FAIL age_stall_cycle got %0d want %0d", first, AGE + 1); end
        n_chk++;
        if ({we[5], wa[5], wd[5]} !== {1'b1, 5'd6, 32'h66}) begin
            n_fail++; $display("FAIL age_r6 got %b/%0d/%h want 1/6/66", we[5], wa[5], wd[5]);
        end
        n_chk++;
        if ({we[6], wa[6], wd[6]} !== {1'b1, 5'd7, 32'h77}) begin
            n_fail++; $display("FAIL age_r7 got %b/%0d/%h want 1/7/77", we[6], wa[6], wd[6]);
        end
        n_chk++;
        if ({st[7], we[7], wa[7]} !== {1'b0, 1'b1, 5'd20}) begin
            n_fail++; $display("FAIL age_release got st/we/wa=%b/%b/%0d want 0/1/20", st[7], we[7], wa[7]);
        end
    endtask

    task automatic test_squash();
        int stale;
        idle();
        wb_we = 1; wb_waddr = 5'd20; wb_wdata = 32'h5;
        lu_valid = 1; lu_waddr = 5'd8; lu_wdata = 32'hAA; raddr1 = 5'd8;
        tick();
        n_chk++;
        if (s_p1 !== 1'b0) begin n_fail++; $display("FAIL sq_pend_pre got %b want 0", s_p1); end
        lu_valid = 0; wb_waddr = 5'd8; wb_wdata = 32'hBB;
        tick();
        n_chk++;
        if ({s_we, s_wa, s_wd, s_p1} !== {1'b1, 5'd8, 32'hBB, 1'b1}) begin
            n_fail++; $display("FAIL sq_wb got %b/%0d/%h p1=%b want 1/8/bb p1=1", s_we, s_wa, s_wd, s_p1);
        end
        wb_we = 0;
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) begin
                n_chk++;
                if (s_p1 !== 1'b0) begin n_fail++; $display("FAIL sq_pend_drop got %b want 0", s_p1); end
            end
            if (s_we === 1'b1) stale++;
        end
        n_chk++;
        if (stale != 0) begin n_fail++; $display("FAIL sq_stale_write got %0d writes want 0", stale); end
    endtask

    task automatic test_pend();
        idle();
        wb_we = 1; wb_waddr = 5'd20;
        lu_valid = 1; lu_waddr = 5'd9; lu_wdata = 32'h99;
        raddr1 = 5'd9; raddr2 = 5'd9;
        tick();
        lu_valid = 0;
        tick();
        n_chk++;
        if ({s_p1, s_p2, s_wa} !== {2'b11, 5'd20}) begin
            n_fail++; $display("FAIL pend_stored got p1p2=%b wa=%0d want 11/20", {s_p1, s_p2}, s_wa);
        end
        wb_we = 0;
        tick();
        n_chk++;
        if ({s_we, s_wa, s_wd, s_p1} !== {1'b1, 5'd9, 32'h99, 1'b1}) begin
            n_fail++; $display("FAIL pend_write got %b/%0d/%h p1=%b want 1/9/99 p1=1", s_we, s_wa, s_wd, s_p1);
        end
        tick();
        n_chk++;
        if ({s_p1, s_p2} !== 2'b00) begin n_fail++; $display("FAIL pend_clear got %b want 00", {s_p1, s_p2}); end
        lu_valid = 1; lu_waddr = 5'd0; lu_wdata = 32'hDEAD; raddr1 = 5'd0; raddr2 = 5'd0;
        tick();
        tick();
        lu_valid = 0;
        tick();
        n_chk++;
        if ({s_we, s_p1, s_p2, s_rdy} !== 4'b0001) begin
            n_fail++; $display("FAIL pend_x0 got we/p1/p2/rdy=%b want 0001", {s_we, s_p1, s_p2, s_rdy});
        end
    endtask

    task automatic test_async_reset();
        int k, wr;
        idle();
        wb_we = 1; wb_waddr = 5'd20; raddr1 = 5'd11; raddr2 = 5'd12;
        lu_valid = 1; lu_waddr = 5'd11; lu_wdata = 32'hB1;
        tick();
        lu_waddr = 5'd12; lu_wdata = 32'hC2;
        tick();
        lu_valid = 0;
        k = 0;
        while (!m_stall && k < 12) begin tick(); k++; end
        n_chk++;
        if (!m_stall) begin n_fail++; $display("FAIL ar_stall_timeout got %0d cycles want stall", k); end
        #3;
        n_chk++;
        if ({rf_we, stall_req, pend1, pend2, lu_ready} !== 5'b11110) begin
            n_fail++; $display("FAIL ar_pre got %b want 11110", {rf_we, stall_req, pend1, pend2, lu_ready});
        end
        rst = 1;
        #1;
        n_chk++;
        if ({rf_we, stall_req, pend1, pend2, lu_ready} !== 5'b00001) begin
            n_fail++; $display("FAIL ar_drop got %b want 00001", {rf_we, stall_req, pend1, pend2, lu_ready});
        end
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        wb_we = 0;
        wr = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (s_we === 1'b1 || s_p1 === 1'b1 || s_p2 === 1'b1) wr++;
        end
        n_chk++;
        if (wr != 0) begin n_fail++; $display("FAIL ar_stale got %0d busy cycles want 0", wr); end
    endtask

    task automatic test_random();
        logic [41:0] got, exp;
        for (int c = 0; c < 600; c++) begin
            wb_we    = ($urandom_range(99) < 55);
            wb_waddr = 5'($urandom_range(7));
            wb_wdata = $urandom;
            lu_valid = ($urandom_range(99) < 50);
            lu_waddr = 5'($urandom_range(7));
            lu_wdata = $urandom;
            raddr1   = 5'($urandom_range(7));
            raddr2   = 5'($urandom_range(7));
            tick();
            got = {s_we, s_we ? {s_wa, s_wd} : 37'd0, s_rdy, s_p1, s_p2, s_st};
            exp = {e_we, e_we ? {e_wa, e_wd} : 37'd0, e_rdy, e_p1, e_p2, e_st};
            n_chk++;
            if (got !== exp) begin
                n_fail++; $display("FAIL random cyc=%0d got %h want %h", c, got, exp);
            end
        end
        idle();
        repeat (4) tick();
    endtask

`ifdef ARB_FWD_BUS_EN
    task automatic test_fwd_bus();
        idle();
        lu_valid = 1; lu_waddr = 5'd10; lu_wdata = 32'h1234;
        tick();
        lu_valid = 0;
        tick();
        n_chk++;
        if (s_bus !== {1'b1, 5'd10, 32'h1234}) begin
            n_fail++; $display("FAIL fwd_bus got %h want %h", s_bus, {1'b1, 5'd10, 32'h1234});
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lu_basic();
        test_stall_age();
        test_squash();
        test_pend();
        test_async_reset();
`ifdef ARB_FWD_BUS_EN
        test_fwd_bus();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wport_arb.md
REGFILE_WPORT_ARB -- requirements
Module: regfile_wport_arb

Interface
REQ-001 SHALL have parameter AGE_MAX, default 4: consecutive blocked cycles of a pending long-unit write before stall_req asserts; legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port wb_we / wb_waddr / wb_wdata  input  1/5/32  pipeline WB write request.
REQ-005 SHALL have port lu_valid / lu_waddr / lu_wdata  input  1/5/32  long-latency unit (div/mul) result offer.
REQ-006 SHALL have port lu_ready  output  1  FIFO can accept the offer this cycle.
REQ-007 SHALL have port rf_we / rf_waddr / rf_wdata  output  1/5/32  granted write to the register file write port.
REQ-008 SHALL have port raddr1 / raddr2  input  5/5  ID-stage read addresses.
REQ-009 SHALL have port pend1 / pend2  output  1/1  a stored FIFO entry targets raddr1 / raddr2 (ID must stall).
REQ-010 SHALL have port stall_req  output  1  registered request for a WB bubble.

Function
REQ-011 SHALL hold a 2-entry in-order FIFO of {waddr, wdata} for long-unit results.
REQ-012 SHALL drive lu_ready = not full; a push occurs on lu_valid && lu_ready at the clock edge; no same-cycle pass-through, minimum LU-to-rf_we latency 1 cycle.
REQ-013 SHALL discard (accept, not store) an LU offer with lu_waddr == 0.
REQ-014 SHALL grant WB when wb_we=1 and stall_req=0: rf_* = wb_* combinationally, zero latency.
REQ-015 SHALL grant the FIFO head when FIFO non-empty and (wb_we=0 or stall_req=1), popping it at the edge; rf_we=0 when neither grants.
REQ-016 SHALL, when stall_req=1 and wb_we=1, give the FIFO precedence; the pipeline contract is wb_we=0 whenever stall_req=1, and any such write is dropped.
REQ-017 SHALL keep a 4-bit age counter: increments each cycle the FIFO is non-empty and head not granted; clears on head pop or FIFO empty; saturates at 15.
REQ-018 SHALL set stall_req at the edge when age counter reaches AGE_MAX-1 while still blocked, and clear it at the edge after the head pop.
REQ-019 SHALL invalidate any stored entry whose waddr equals wb_waddr in a cycle where WB is granted with wb_waddr != 0 (WAW squash; WB is younger); the entry being pushed in the same cycle is not squashed.
REQ-020 SHALL compute pend1/pend2 combinationally over valid stored entries only; address 0 never pending.
REQ-021 SHALL on simultaneous push and pop with one entry stored keep occupancy 1 with the new entry as head; push and pop when full is impossible (lu_ready=0).
REQ-022 SHALL, after squash leaves the head invalid, skip it (pop without granting) in the same cycle as the next grant decision, with no rf_we for the skipped entry.

Reset
REQ-023 SHALL on rst=1, immediately and regardless of clk, empty the FIFO, clear age counter, and drive rf_we=0, stall_req=0, pend1=pend2=0, lu_ready=1.
REQ-024 SHALL discard in-flight FIFO contents on reset mid-operation; no write after reset deasserts until new requests arrive.

Configuration
REQ-025 SHALL, with macro ARB_FWD_BUS_EN defined, add output arb_to_id_bus [37:0] = {rf_we, rf_waddr, rf_wdata} of the current grant, same packing as the other stage-to-ID forwarding buses, so ID can bypass the write in-flight.
REQ-026 SHALL, without ARB_FWD_BUS_EN, omit that port and all its logic; other behaviour identical.

Verification
REQ-027 SHALL test: lu_valid, waddr=5, data=0x11 with wb_we=0 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x11, FIFO empty.
REQ-028 SHALL test: two LU pushes (r6, r7) while wb_we=1 continuously -> lu_ready=0 after second push; stall_req=1 after AGE_MAX blocked cycles; r6 then r7 written on consecutive cycles; stall_req falls after r6 pop.
REQ-029 SHALL test: LU push r8=0xAA stored, then WB writes r8=0xBB -> entry squashed, pend for r8 drops, r8 never written with 0xAA.
REQ-030 SHALL test: LU push r9 stored, raddr1=9 -> pend1=1 until the cycle after rf_we for r9; lu_waddr=0 offer -> no pend, no write.
REQ-031 SHALL test: rst pulsed asynchronously mid-cycle with FIFO full -> rf_we, stall_req, pend1/2 drop immediately; lu_ready=1; no stale write afterwards.
REQ-032 SHALL test, with ARB_FWD_BUS_EN: FIFO grant of r10=0x1234 -> arb_to_id_bus = {1, 10, 0x1234} in the same cycle.
